backstabber_axi4_burst_slave: RTL and testbench

AXI4 full-protocol burst responder with a small internal register-file memory. It is the receiving end for the backstabber M00_AXI burst initiator and gives block-level benches a synthesizable target in place of a VIP slave. It accepts INCR/FIXED/WRAP write and read bursts, one outstanding transaction per direction, and returns B/R responses with ID echo.

---
 rtl/backstabber_axi_pkg.sv | 48 ++++
 rtl/backstabber_burst_addr_gen.sv | 46 ++++
 rtl/backstabber_axi4_burst_slave.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_backstabber_axi4_burst_slave.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/backstabber_axi_pkg.sv
// Shared types and constants for the backstabber AXI4 burst slave.
// Holds the burst encoding, response codes, FSM state enums and the
// latched burst-control payload used by the write and read paths.
package backstabber_axi_pkg;

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;

    typedef enum logic [BURST_W-1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_t;

    // Encoding 2'b11 is reserved by AXI and always answered with SLVERR.
    localparam logic [BURST_W-1:0] BURST_RSVD = 2'b11;

    localparam logic [RESP_W-1:0] OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] SLVERR = 2'b10;

    // Only full 32-bit beats are supported.
    localparam logic [SIZE_W-1:0] SIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Burst control kept for the lifetime of an accepted transaction.
    typedef struct packed {
        logic [LEN_W-1:0]   len;
        logic [BURST_W-1:0] burst;
    } ax_ctrl_t;

    // WRAP bursts must span 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/backstabber_burst_addr_gen.sv
// Burst word-index generator.
// Ports:
//   req_addr/req_len/req_size/req_burst : live AxADDR channel payload
//   cur_idx/cur_len/cur_burst           : index and control of the burst in flight
//   start_idx_c                         : word index of beat 0 for the request
//   next_idx_c                          : word index following cur_idx
//   legal_c                             : request is servable (else SLVERR)
module backstabber_burst_addr_gen
    import backstabber_axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned IDX_W  = 4
) (
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [LEN_W-1:0]   req_len,
    input  logic [SIZE_W-1:0]  req_size,
    input  logic [BURST_W-1:0] req_burst,
    input  logic [IDX_W-1:0]   cur_idx,
    input  logic [LEN_W-1:0]   cur_len,
    input  logic [BURST_W-1:0] cur_burst,
    output logic [IDX_W-1:0]   start_idx_c,
    output logic [IDX_W-1:0]   next_idx_c,
    output logic               legal_c
);

    logic [IDX_W-1:0] wrap_mask;
    logic [IDX_W-1:0] incr_idx;

    // Upper address bits fall off in the cast, so addresses alias over the memory.
    always_comb begin
        start_idx_c = IDX_W'(req_addr >> 2);
        legal_c     = (req_size == SIZE_WORD) && (req_burst != BURST_RSVD) &&
                      ((req_burst != BURST_W'(WRAP)) || wrap_len_ok(req_len));

        // For a legal WRAP, len is 2^n-1 and doubles as the in-window bit mask.
        wrap_mask  = IDX_W'(cur_len);
        incr_idx   = cur_idx + IDX_W'(1);
        next_idx_c = cur_idx;
        case (burst_t'(cur_burst))
            INCR:    next_idx_c = incr_idx;
            WRAP:    next_idx_c = (cur_idx & ~wrap_mask) | (incr_idx & wrap_mask);
            default: next_idx_c = cur_idx;
        endcase
    end

endmodule

// File: rtl/backstabber_axi4_burst_slave.sv
// AXI4 burst slave backed by a small word-addressed register file.
// One outstanding write and one outstanding read, handled by independent
// FSMs; INCR/FIXED/WRAP bursts, ID echo, SLVERR for unsupported requests.
// Ports:
//   ACLK, ARESETN        : clock, asynchronous active-low reset
//   S_AXI_AW* / W* / B*  : write address, write data, write response channels
//   S_AXI_AR* / R*       : read address, read data channels
module backstabber_axi4_burst_slave
    import backstabber_axi_pkg::*;
#(
    parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
    parameter int unsigned C_MEM_DEPTH        = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [LEN_W-1:0]                  S_AXI_AWLEN,
    input  logic [SIZE_W-1:0]                 S_AXI_AWSIZE,
    input  logic [BURST_W-1:0]                S_AXI_AWBURST,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WLAST,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
    output logic [RESP_W-1:0]                 S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [LEN_W-1:0]                  S_AXI_ARLEN,
    input  logic [SIZE_W-1:0]                 S_AXI_ARSIZE,
    input  logic [BURST_W-1:0]                S_AXI_ARBURST,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [RESP_W-1:0]                 S_AXI_RRESP,
    output logic                              S_AXI_RLAST,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int unsigned IDX_W  = $clog2(C_MEM_DEPTH);
    localparam int unsigned DATA_W = C_S_AXI_DATA_WIDTH;
    localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned ID_W   = C_S_AXI_ID_WIDTH;

    logic [DATA_W-1:0] mem [C_MEM_DEPTH];

    // Write path state
    wr_state_t         w_state, w_state_next;
    logic [IDX_W-1:0]  w_idx, w_idx_next;
    ax_ctrl_t          w_ctrl, w_ctrl_next;
    logic [LEN_W-1:0]  w_cnt, w_cnt_next;
    logic              w_err, w_err_next;
    logic              w_over, w_over_next;
    logic              awready_next, wready_next, bvalid_next;
    logic [ID_W-1:0]   bid_next;
    logic [RESP_W-1:0] bresp_next;
    logic [STRB_W-1:0] mem_we_c;
    logic [IDX_W-1:0]  aw_start_c, w_next_c;
    logic              aw_legal_c;

    // Read path state
    rd_state_t         r_state, r_state_next;
    logic [IDX_W-1:0]  r_idx, r_idx_next;
    ax_ctrl_t          r_ctrl, r_ctrl_next;
    logic [LEN_W-1:0]  r_cnt, r_cnt_next;
    logic              r_err, r_err_next;
    logic              arready_next, rvalid_next, rlast_next;
    logic [ID_W-1:0]   rid_next;
    logic [DATA_W-1:0] rdata_next;
    logic [RESP_W-1:0] rresp_next;
    logic [IDX_W-1:0]  ar_start_c, r_next_c;
    logic              ar_legal_c;

    backstabber_burst_addr_gen #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH),
        .IDX_W  (IDX_W)
    ) u_wr_addr (
        .req_addr    (S_AXI_AWADDR),
        .req_len     (S_AXI_AWLEN),
        .req_size    (S_AXI_AWSIZE),
        .req_burst   (S_AXI_AWBURST),
        .cur_idx     (w_idx),
        .cur_len     (w_ctrl.len),
        .cur_burst   (w_ctrl.burst),
        .start_idx_c (aw_start_c),
        .next_idx_c  (w_next_c),
        .legal_c     (aw_legal_c)
    );

    backstabber_burst_addr_gen #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH),
        .IDX_W  (IDX_W)
    ) u_rd_addr (
        .req_addr    (S_AXI_ARADDR),
        .req_len     (S_AXI_ARLEN),
        .req_size    (S_AXI_ARSIZE),
        .req_burst   (S_AXI_ARBURST),
        .cur_idx     (r_idx),
        .cur_len     (r_ctrl.len),
        .cur_burst   (r_ctrl.burst),
        .start_idx_c (ar_start_c),
        .next_idx_c  (r_next_c),
        .legal_c     (ar_legal_c)
    );

    // Write FSM: next state, registered-output next values, byte enables.
    always_comb begin
        w_state_next = w_state;
        w_idx_next   = w_idx;
        w_ctrl_next  = w_ctrl;
        w_cnt_next   = w_cnt;
        w_err_next   = w_err;
        w_over_next  = w_over;
        awready_next = S_AXI_AWREADY;
        wready_next  = S_AXI_WREADY;
        bvalid_next  = S_AXI_BVALID;
        bid_next     = S_AXI_BID;
        bresp_next   = S_AXI_BRESP;
        mem_we_c     = '0;

        unique case (w_state)
            W_IDLE: begin
                awready_next = 1'b1;
                if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                    w_state_next = W_DATA;
                    awready_next = 1'b0;
                    wready_next  = 1'b1;
                    bid_next     = S_AXI_AWID;
                    w_idx_next   = aw_start_c;
                    w_ctrl_next  = '{len: S_AXI_AWLEN, burst: S_AXI_AWBURST};
                    w_cnt_next   = '0;
                    w_err_next   = !aw_legal_c;
                    w_over_next  = 1'b0;
                end
            end
            W_DATA: begin
                if (S_AXI_WVALID && S_AXI_WREADY) begin
                    // Beats past AWLEN (w_over) and illegal bursts are swallowed.
                    if (!w_err && !w_over) begin
                        mem_we_c = S_AXI_WSTRB;
                    end
                    if (S_AXI_WLAST) begin
                        w_state_next = W_RESP;
                        wready_next  = 1'b0;
                        bvalid_next  = 1'b1;
                        bresp_next   = (w_err || w_over || (w_cnt != w_ctrl.len)) ? SLVERR : OKAY;
                    end else if (w_cnt == w_ctrl.len) begin
                        w_over_next = 1'b1;
                    end else begin
                        w_cnt_next = w_cnt + 8'd1;
                        w_idx_next = w_next_c;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BVALID && S_AXI_BREADY) begin
                    w_state_next = W_IDLE;
                    bvalid_next  = 1'b0;
                    awready_next = 1'b1;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // Read FSM: data is fetched one cycle ahead so RDATA comes straight from a flop.
    always_comb begin
        r_state_next = r_state;
        r_idx_next   = r_idx;
        r_ctrl_next  = r_ctrl;
        r_cnt_next   = r_cnt;
        r_err_next   = r_err;
        arready_next = S_AXI_ARREADY;
        rvalid_next  = S_AXI_RVALID;
        rid_next     = S_AXI_RID;
        rdata_next   = S_AXI_RDATA;
        rresp_next   = S_AXI_RRESP;
        rlast_next   = S_AXI_RLAST;

        unique case (r_state)
            R_IDLE: begin
                arready_next = 1'b1;
                if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                    r_state_next = R_DATA;
                    arready_next = 1'b0;
                    rvalid_next  = 1'b1;
                    rid_next     = S_AXI_ARID;
                    r_idx_next   = ar_start_c;
                    r_ctrl_next  = '{len: S_AXI_ARLEN, burst: S_AXI_ARBURST};
                    r_cnt_next   = '0;
                    r_err_next   = !ar_legal_c;
                    rdata_next   = ar_legal_c ? mem[ar_start_c] : '0;
                    rresp_next   = ar_legal_c ? OKAY : SLVERR;
                    rlast_next   = (S_AXI_ARLEN == 8'd0);
                end
            end
            R_DATA: begin
                if (S_AXI_RVALID && S_AXI_RREADY) begin
                    if (S_AXI_RLAST) begin
                        r_state_next = R_IDLE;
                        rvalid_next  = 1'b0;
                        rlast_next   = 1'b0;
                        arready_next = 1'b1;
                    end else begin
                        r_cnt_next = r_cnt + 8'd1;
                        r_idx_next = r_next_c;
                        rdata_next = r_err ? '0 : mem[r_next_c];
                        rresp_next = r_err ? SLVERR : OKAY;
                        rlast_next = ((r_cnt + 8'd1) == r_ctrl.len);
                    end
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state       <= W_IDLE;
            w_idx         <= '0;
            w_ctrl        <= '0;
            w_cnt         <= '0;
            w_err         <= 1'b0;
            w_over        <= 1'b0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BID     <= '0;
            S_AXI_BRESP   <= '0;
            r_state       <= R_IDLE;
            r_idx         <= '0;
            r_ctrl        <= '0;
            r_cnt         <= '0;
            r_err         <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RID     <= '0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= '0;
            S_AXI_RLAST   <= 1'b0;
        end else begin
            w_state       <= w_state_next;
            w_idx         <= w_idx_next;
            w_ctrl        <= w_ctrl_next;
            w_cnt         <= w_cnt_next;
            w_err         <= w_err_next;
            w_over        <= w_over_next;
            S_AXI_AWREADY <= awready_next;
            S_AXI_WREADY  <= wready_next;
            S_AXI_BVALID  <= bvalid_next;
            S_AXI_BID     <= bid_next;
            S_AXI_BRESP   <= bresp_next;
            r_state       <= r_state_next;
            r_idx         <= r_idx_next;
            r_ctrl        <= r_ctrl_next;
            r_cnt         <= r_cnt_next;
            r_err         <= r_err_next;
            S_AXI_ARREADY <= arready_next;
            S_AXI_RVALID  <= rvalid_next;
            S_AXI_RID     <= rid_next;
            S_AXI_RDATA   <= rdata_next;
            S_AXI_RRESP   <= rresp_next;
            S_AXI_RLAST   <= rlast_next;
        end
    end

    // Register-file storage; deliberately not reset.
    always_ff @(posedge ACLK) begin
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (mem_we_c[b]) begin
                mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_backstabber_axi4_burst_slave.sv
// Self-checking bench for backstabber_axi4_burst_slave: directed test-plan
// bursts plus randomized bursts scored against a word-array memory model.
module tb_backstabber_axi4_burst_slave;

    logic        ACLK;
    logic        ARESETN;
    logic [0:0]  S_AXI_AWID;
    logic [7:0]  S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic [2:0]  S_AXI_AWSIZE;
    logic [1:0]  S_AXI_AWBURST;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [0:0]  S_AXI_BID;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [0:0]  S_AXI_ARID;
    logic [7:0]  S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic [2:0]  S_AXI_ARSIZE;
    logic [1:0]  S_AXI_ARBURST;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [0:0]  S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    backstabber_axi4_burst_slave #(
        .C_S_AXI_ID_WIDTH   (1),
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (8),
        .C_MEM_DEPTH        (16)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWID    (S_AXI_AWID),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWLEN   (S_AXI_AWLEN),
        .S_AXI_AWSIZE  (S_AXI_AWSIZE),
        .S_AXI_AWBURST (S_AXI_AWBURST),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WLAST   (S_AXI_WLAST),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BID     (S_AXI_BID),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARID    (S_AXI_ARID),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARLEN   (S_AXI_ARLEN),
        .S_AXI_ARSIZE  (S_AXI_ARSIZE),
        .S_AXI_ARBURST (S_AXI_ARBURST),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RID     (S_AXI_RID),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RLAST   (S_AXI_RLAST),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [16];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Word index of a beat, straight from the burst rules.
    function automatic int widx(input logic [7:0] addr, input int len, input logic [1:0] burst, input int beat);
        int start, n, base;
        start = (int'(addr) / 4) % 16;
        if (burst == 2'd0) return start;
        if (burst == 2'd1) return (start + beat) % 16;
        n    = len + 1;
        base = start - (start % n);
        return base + ((start % n) + beat) % n;
    endfunction

    function automatic bit legal(input logic [2:0] size, input logic [1:0] burst, input int len);
        if (size != 3'd2 || burst == 2'd3) return 1'b0;
        if (burst == 2'd2) return (len == 1 || len == 3 || len == 7 || len == 15);
        return 1'b1;
    endfunction

    // Full write transaction; abort_after >= 0 stops before that W beat (no B phase).
    task automatic do_write(input logic [0:0] id, input logic [7:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                            input int bstall, input int abort_after);
        int g;
        bit lg;
        int ix;
        logic [1:0] exp_resp;
        lg = legal(size, burst, len);
        exp_resp = (lg && nbeats == len + 1) ? 2'b00 : 2'b10;
        S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len);
        S_AXI_AWSIZE = size; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
        g = 0;
        while (!S_AXI_AWREADY && g < 50) begin @(negedge ACLK); g++; end
        chk("awready_wait", 32'(S_AXI_AWREADY), 32'd1);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        chk("wready_after_aw", 32'(S_AXI_WREADY), 32'd1);
        chk("awready_busy", 32'(S_AXI_AWREADY), 32'd0);
        for (int i = 0; i < nbeats; i++) begin
            if (abort_after >= 0 && i == abort_after) begin
                S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
                return;
            end
            S_AXI_WVALID = 1'b1; S_AXI_WDATA = wd[i]; S_AXI_WSTRB = ws[i];
            S_AXI_WLAST = (i == nbeats - 1);
            g = 0;
            while (!S_AXI_WREADY && g < 50) begin @(negedge ACLK); g++; end
            chk("wready_wait", 32'(S_AXI_WREADY), 32'd1);
            @(negedge ACLK);
            if (lg && i <= len) begin
                ix = widx(addr, len, burst, i);
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) model[ix][8*b +: 8] = wd[i][8*b +: 8];
            end
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        chk("bvalid", 32'(S_AXI_BVALID), 32'd1);
        chk("bid", 32'(S_AXI_BID), 32'(id));
        chk("bresp", 32'(S_AXI_BRESP), 32'(exp_resp));
        for (int k = 0; k < bstall; k++) begin
            @(negedge ACLK);
            chk("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
            chk("bid_hold", 32'(S_AXI_BID), 32'(id));
            chk("bresp_hold", 32'(S_AXI_BRESP), 32'(exp_resp));
        end
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        chk("bvalid_clear", 32'(S_AXI_BVALID), 32'd0);
        chk("awready_back", 32'(S_AXI_AWREADY), 32'd1);
    endtask

    // Full read transaction; stall toggles RREADY; abort_after >= 0 leaves mid-burst.
    task automatic do_read(input logic [0:0] id, input logic [7:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input bit stall,
                           input int abort_after);
        int g, beat;
        bit lg, tog, rr;
        logic [31:0] exp_data;
        lg = legal(size, burst, len);
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len);
        S_AXI_ARSIZE = size; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
        g = 0;
        while (!S_AXI_ARREADY && g < 50) begin @(negedge ACLK); g++; end
        chk("arready_wait", 32'(S_AXI_ARREADY), 32'd1);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        chk("arready_busy", 32'(S_AXI_ARREADY), 32'd0);
        beat = 0; g = 0; tog = 1'b0;
        while (beat <= len && g < 1000) begin
            if (abort_after >= 0 && beat == abort_after) begin
                S_AXI_RREADY = 1'b0;
                return;
            end
            exp_data = lg ? model[widx(addr, len, burst, beat)] : 32'd0;
            chk("rvalid", 32'(S_AXI_RVALID), 32'd1);
            chk("rdata", S_AXI_RDATA, exp_data);
            chk("rresp", 32'(S_AXI_RRESP), lg ? 32'd0 : 32'd2);
            chk("rlast", 32'(S_AXI_RLAST), 32'(beat == len));
            chk("rid", 32'(S_AXI_RID), 32'(id));
            rr = stall ? tog : 1'b1;
            tog = !tog;
            S_AXI_RREADY = rr;
            @(negedge ACLK);
            if (rr) beat++;
            g++;
        end
        S_AXI_RREADY = 1'b0;
        chk("read_beats", 32'(beat), 32'(len + 1));
        chk("rvalid_clear", 32'(S_AXI_RVALID), 32'd0);
        chk("arready_back", 32'(S_AXI_ARREADY), 32'd1);
    endtask

    task automatic chk_all_idle_outputs(input string tag);
        chk({tag, "_awready"}, 32'(S_AXI_AWREADY), 32'd0);
        chk({tag, "_wready"},  32'(S_AXI_WREADY),  32'd0);
        chk({tag, "_bvalid"},  32'(S_AXI_BVALID),  32'd0);
        chk({tag, "_bresp"},   32'(S_AXI_BRESP),   32'd0);
        chk({tag, "_arready"}, 32'(S_AXI_ARREADY), 32'd0);
        chk({tag, "_rvalid"},  32'(S_AXI_RVALID),  32'd0);
        chk({tag, "_rresp"},   32'(S_AXI_RRESP),   32'd0);
        chk({tag, "_rdata"},   S_AXI_RDATA,        32'd0);
        chk({tag, "_rlast"},   32'(S_AXI_RLAST),   32'd0);
    endtask

    initial begin
        int r, len, nb;
        logic [7:0] addr;
        logic [1:0] burst;
        logic [2:0] size;

        ARESETN = 1'b0;
        S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0;
        S_AXI_AWBURST = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = '0;
        S_AXI_ARBURST = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 32'd0;

        // Reset state, then READY rises on the first edge after release.
        repeat (3) @(negedge ACLK);
        chk_all_idle_outputs("reset");
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("awready_post_reset", 32'(S_AXI_AWREADY), 32'd1);
        chk("arready_post_reset", 32'(S_AXI_ARREADY), 32'd1);

        // Give every word a known value.
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(1'b0, 8'h00, 15, 3'd2, 2'd1, 16, 0, -1);

        // INCR 8 beats, data 1..8.
        for (int i = 0; i < 8; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(1'b0, 8'h00, 7, 3'd2, 2'd1, 8, 0, -1);
        do_read(1'b0, 8'h00, 7, 3'd2, 2'd1, 1'b0, -1);

        // WRAP 4 beats from word 2.
        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(1'b0, 8'h08, 3, 3'd2, 2'd2, 4, 0, -1);
        do_read(1'b0, 8'h08, 3, 3'd2, 2'd2, 1'b0, -1);
        do_read(1'b0, 8'h00, 3, 3'd2, 2'd1, 1'b0, -1);

        // Byte strobes: all-ones, then zeros on lanes 0 and 2.
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        do_write(1'b0, 8'h30, 0, 3'd2, 2'd1, 1, 0, -1);
        wd[0] = 32'h0000_0000; ws[0] = 4'h5;
        do_write(1'b0, 8'h30, 0, 3'd2, 2'd1, 1, 0, -1);
        do_read(1'b0, 8'h30, 0, 3'd2, 2'd1, 1'b0, -1);

        // Reserved burst type and narrow read size.
        wd[0] = 32'hDEAD_0001; wd[1] = 32'hDEAD_0002; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(1'b0, 8'h10, 1, 3'd2, 2'd3, 2, 0, -1);
        do_read(1'b0, 8'h10, 1, 3'd2, 2'd1, 1'b0, -1);
        do_read(1'b0, 8'h10, 1, 3'd1, 2'd1, 1'b0, -1);

        // Back-pressure with ID 1.
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(1'b1, 8'h20, 7, 3'd2, 2'd1, 8, 10, -1);
        do_read(1'b1, 8'h20, 7, 3'd2, 2'd1, 1'b1, -1);

        // WLAST early and late.
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(1'b0, 8'h04, 3, 3'd2, 2'd1, 2, 0, -1);
        do_write(1'b1, 8'h14, 2, 3'd2, 2'd1, 5, 0, -1);
        do_read(1'b0, 8'h00, 15, 3'd2, 2'd1, 1'b0, -1);

        // Independent channels accept concurrently (disjoint words).
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        fork
            do_write(1'b1, 8'h00, 3, 3'd2, 2'd1, 4, 0, -1);
            do_read(1'b0, 8'h20, 3, 3'd2, 2'd1, 1'b0, -1);
        join

        // Randomized bursts.
        for (int t = 0; t < 30; t++) begin
            addr = 8'($urandom);
            r = int'($urandom_range(0, 9));
            burst = (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : (r < 9) ? 2'd0 : 2'd3;
            if (burst == 2'd2) begin
                r = int'($urandom_range(0, 4));
                len = (r == 0) ? 1 : (r == 1) ? 3 : (r == 2) ? 7 : (r == 3) ? 15 : 2;
            end else begin
                len = int'($urandom_range(0, 9));
            end
            size = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
            nb = len + 1;
            r = int'($urandom_range(0, 9));
            if (r == 0) nb = len + 2;
            else if (r == 1 && len > 0) nb = len;
            for (int i = 0; i < nb; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            do_write(1'($urandom), addr, len, size, burst, nb, int'($urandom_range(0, 3)), -1);
            do_read(1'($urandom), addr, len, size, burst, 1'($urandom), -1);
        end

        // Reset during beat 3 of an 8-beat write.
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(1'b0, 8'h00, 7, 3'd2, 2'd1, 8, 0, 3);
        #2 ARESETN = 1'b0;
        #1 chk_all_idle_outputs("reset_mid_write");
        @(negedge ACLK);
        #2 ARESETN = 1'b1;
        #1 chk("awready_release_low", 32'(S_AXI_AWREADY), 32'd0);
        @(negedge ACLK);
        chk("awready_release", 32'(S_AXI_AWREADY), 32'd1);
        chk("arready_release", 32'(S_AXI_ARREADY), 32'd1);

        // Reset during a read.
        do_read(1'b1, 8'h00, 7, 3'd2, 2'd1, 1'b0, 2);
        #2 ARESETN = 1'b0;
        #1 chk_all_idle_outputs("reset_mid_read");
        @(negedge ACLK);
        #2 ARESETN = 1'b1;
        @(negedge ACLK);

        // Clean traffic after recovery.
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(1'b1, 8'h20, 7, 3'd2, 2'd1, 8, 0, -1);
        do_read(1'b1, 8'h20, 7, 3'd2, 2'd1, 1'b0, -1);
        do_read(1'b0, 8'h00, 15, 3'd2, 2'd1, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
